// File: rtl/rt_pkg.sv
// Shared definitions for the real-time note sequencer: state encoding,
// song ROM entry layout and the special rest / end-of-song codes.
package rt_pkg;

    // Default song ROM depth is 2^7 = 128 entries
    localparam int ADDR_W_DEF = 7;

    // Song ROM entry layout: {note[11:6], duration[5:0]}
    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    // A zero note is a timed rest; a zero duration marks the end of the song
    localparam int REST_NOTE = 0;
    localparam int END_DUR   = 0;

    // State encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_FETCH = S_FETCH,
        ST_LOAD  = S_LOAD,
        ST_PLAY  = S_PLAY,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/rt_note_sequencer_if.sv
// Bundle between the note sequencer, its song ROM and the note player.
// The sequencer takes the slave side; the environment drives the master side.
interface rt_note_sequencer_if
    import rt_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int NOTE_WIDTH = NOTE_MSB - NOTE_LSB + 1,
    parameter int DUR_WIDTH  = DUR_MSB - DUR_LSB + 1
);

    logic                            play;
    logic                            beat;
    logic [ADDR_WIDTH-1:0]           rom_addr;
    logic [NOTE_WIDTH+DUR_WIDTH-1:0] rom_data;
    logic [NOTE_WIDTH-1:0]           note_to_load;
    logic                            play_enable;
    logic                            song_done;
    logic                            busy;

    modport slave (
        input  play, beat, rom_data,
        output rom_addr, note_to_load, play_enable, song_done, busy
    );

    modport master (
        output play, beat, rom_data,
        input  rom_addr, note_to_load, play_enable, song_done, busy
    );

endinterface

// File: rtl/dffre.sv
// Generic register with synchronous active-high reset and load enable.
module dffre #(
    parameter int            W         = 1,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Reset wins over enable; otherwise capture d only when enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/rt_note_sequencer_beat_counter.sv
// Loadable down-counter holding the remaining beats of the current note.
// 'last' flags the decrement that consumes the final beat.
module beat_counter #(
    parameter int DUR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DUR_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic                 last
);

    logic [DUR_WIDTH-1:0] count_q;
    logic [DUR_WIDTH-1:0] count_d;

    // Load takes priority; otherwise step down by one accepted beat
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec) begin
            count_d = count_q - 1'b1;
        end
    end

    dffre #(.W(DUR_WIDTH)) u_count (
        .clk   (clk),
        .reset (reset),
        .en_i  (load | dec),
        .d_i   (count_d),
        .q_o   (count_q)
    );

    assign last = (count_q == DUR_WIDTH'(1)) && dec;

endmodule

// File: rtl/rt_note_sequencer.sv
// Song ROM walker feeding the note player. Each ROM entry is one note held
// for a number of 48 Hz beats; 'play' pauses playback, a zero duration ends
// the song. The outgoing note is held through FETCH/LOAD so consecutive
// notes follow each other without a gap.
module rt_note_sequencer
    import rt_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int NOTE_WIDTH = NOTE_MSB - NOTE_LSB + 1,
    parameter int DUR_WIDTH  = DUR_MSB - DUR_LSB + 1
) (
    input logic                clk,
    input logic                reset,
    rt_note_sequencer_if.slave bus
);

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            stateRaw;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  addrEn;

    logic [NOTE_WIDTH-1:0] note_q;
    logic                  noteEn;

    logic                  songDone_q;
    logic                  busy_q;

    logic [NOTE_WIDTH-1:0] romNote;
    logic [DUR_WIDTH-1:0]  romDur;

    logic                  cntLoad;
    logic                  cntDec;
    logic                  cntLast;

    assign romNote = bus.rom_data[NOTE_WIDTH+DUR_WIDTH-1:DUR_WIDTH];
    assign romDur  = bus.rom_data[DUR_WIDTH-1:0];

    // A beat only counts while a note is playing and playback is not paused
    assign cntDec = (state_q == ST_PLAY) && bus.beat && bus.play;

    // Next-state, address and load controls for the song walker
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        addrEn  = 1'b0;
        noteEn  = 1'b0;
        cntLoad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.play) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (romDur == DUR_WIDTH'(END_DUR)) begin
                    state_d = ST_DONE;
                end else begin
                    noteEn  = 1'b1;
                    cntLoad = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (cntLast) begin
                    addrEn  = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                addrEn  = 1'b1;
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    dffre #(.W(3), .RESET_VAL(S_IDLE)) u_state (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (state_d),
        .q_o   (stateRaw)
    );

    assign state_q = state_t'(stateRaw);

    dffre #(.W(ADDR_WIDTH)) u_addr (
        .clk   (clk),
        .reset (reset),
        .en_i  (addrEn),
        .d_i   (addr_d),
        .q_o   (addr_q)
    );

    dffre #(.W(NOTE_WIDTH)) u_note (
        .clk   (clk),
        .reset (reset),
        .en_i  (noteEn),
        .d_i   (romNote),
        .q_o   (note_q)
    );

    dffre #(.W(1)) u_song_done (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (state_d == ST_DONE),
        .q_o   (songDone_q)
    );

    dffre #(.W(1)) u_busy (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (state_d != ST_IDLE),
        .q_o   (busy_q)
    );

    beat_counter #(.DUR_WIDTH(DUR_WIDTH)) u_beat_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cntLoad),
        .load_value (romDur),
        .dec        (cntDec),
        .last       (cntLast)
    );

    assign bus.rom_addr     = addr_q;
    assign bus.note_to_load = note_q;
    assign bus.song_done    = songDone_q;
    assign bus.busy         = busy_q;
    assign bus.play_enable  = ((state_q == ST_PLAY) || (state_q == ST_FETCH) || (state_q == ST_LOAD))
                              && bus.play && (note_q != NOTE_WIDTH'(REST_NOTE));

endmodule

// File: doc/rt_note_sequencer.md
# rt_note_sequencer

Upstream stage of the real-time note player. Walks a song ROM, one entry per note, and presents `note_to_load` and `play_enable` to the note player. It holds each note for a programmed number of 1/48 s beats, supports pause through a level `play` input, and stops on an end-of-song marker.

## Interface
Parameters:
- ADDR_WIDTH, 7, song ROM address width (128 entries).
- NOTE_WIDTH, 6, note code width; must match the note player's `note_to_load`.
- DUR_WIDTH, 6, duration field width in beats.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- play  in  1  level; high = advance/sound, low = pause.
- beat  in  1  one-cycle pulse, 48 Hz.
- rom_addr  out  ADDR_WIDTH  song ROM address; registered.
- rom_data  in  NOTE_WIDTH+DUR_WIDTH  {note, duration}, valid exactly 1 cycle after `rom_addr` changes.
- note_to_load  out  NOTE_WIDTH  current note code to the note player.
- play_enable  out  1  high while a non-rest note sounds and `play` is high.
- song_done  out  1  one-cycle pulse when the end marker is reached.
- busy  out  1  high in any state except IDLE.

## Operation
- Entry format: note = rom_data[11:6], duration = rom_data[5:0].
- note == 0 is a rest. It is timed normally, with `play_enable` low.
- duration == 0 is the end marker.
- States:
  - IDLE: waits for `play`=1, then goes to FETCH.
  - FETCH: `rom_addr` is stable. Goes to LOAD next cycle.
  - LOAD: samples `rom_data`.
    - If duration == 0, goes to DONE.
    - Otherwise it loads the note register and sets the beat counter to duration, then goes to PLAY.
  - PLAY: on `beat` && `play`, the counter decrements.
    - On `beat` && `play` with counter == 1: `rom_addr` increments and the state goes to FETCH.
  - DONE: `song_done`=1 for this one cycle. `rom_addr` returns to 0, then the state goes to IDLE.
- Pause: `play`=0 in PLAY freezes the counter and forces `play_enable` low. `note_to_load` holds. Resuming continues the remaining beats.
- `play`=0 in FETCH/LOAD does not stall the fetch. The block lands in PLAY paused.
- `play_enable` = (state==PLAY || state==FETCH || state==LOAD) && play && (note_reg != 0). Previous note and enable hold through FETCH/LOAD, so there is no audible gap between notes.
- Beats arriving in IDLE, FETCH, LOAD or DONE are ignored. This is benign: a beat lasts ≥10⁶ clocks.
- Address wrap: incrementing from 2^ADDR_WIDTH−1 wraps to 0 and playback continues. A ROM with no end marker loops forever.
- `play`=0 in IDLE: stays in IDLE.
- After DONE the song restarts from address 0 if `play` is still high.

## Timing
- Reset values: state=IDLE, rom_addr=0, note_to_load=0, beat counter=0, play_enable=0, song_done=0, busy=0.
- Reset mid-operation aborts immediately, with no `song_done` pulse.
- IDLE → first note on `note_to_load`: 3 cycles after the first cycle `play` is sampled high (IDLE, FETCH, LOAD; valid in cycle 3).
- Note change latency from its final beat: 2 cycles (FETCH, LOAD). The new note appears registered in the first PLAY cycle.
- The note is held for exactly `duration` accepted beats, measured from PLAY entry.
- `song_done`: registered, asserted during the DONE cycle only.
- All outputs are registered except `play_enable`, which is a combinational AND of registered state and the `play` input.

## Structure
- Shared package `rt_pkg`:
  - state encoding localparams (IDLE/FETCH/LOAD/PLAY/DONE);
  - ROM field positions (NOTE_MSB/LSB, DUR_MSB/LSB);
  - constants REST_NOTE=0 and END_DUR=0.
- State, address, note and counter registers use the shared `dffre` enable/reset flop.
- One sub-module: `beat_counter`.
  - Loadable DUR_WIDTH down-counter.
  - Inputs: load, load_value, dec.
  - Output: `last` = (count==1 && dec).

## Test plan
- Reset/idle:
  - Stimulus: hold reset 3 cycles, then play=0 for 100 cycles with beats.
  - Required: all outputs 0, rom_addr=0, busy=0.
- Basic song:
  - Stimulus: ROM {12,3},{20,2},{0,0}; play=1.
  - Required: note 12 for exactly 3 beats, then 20 for 2 beats; then `song_done` 1-cycle pulse, rom_addr=0, IDLE.
  - Required: first note visible 3 cycles after play.
- Rest:
  - Stimulus: ROM {0,2},{7,1},{0,0}.
  - Required: play_enable=0 for 2 beats, then 1 for 1 beat with note 7.
- Pause:
  - Stimulus: note {9,4}; drop play after 2 beats for 5 beats, then restore.
  - Required: play_enable low during the pause; note held; exactly 2 more beats after resume before the fetch.
- Reset mid-note:
  - Stimulus: assert reset during PLAY at address 1.
  - Required: next cycle state=IDLE, all outputs 0, no `song_done`.
- Wrap:
  - Stimulus: ADDR_WIDTH=2, ROM has no end marker, entries {1,1},{2,1},{3,1},{4,1}.
  - Required: the sequence 1,2,3,4,1 with rom_addr wrapping 3→0.
